// File: rtl/fu_wb_requester.sv
// Writeback-request sequencer for one iterative functional unit: launches the core, captures result and tag, raises p_signal.
// Latency: p_signal rises LATENCY cycles after the accepting edge, plus one cycle for every stalled RUN cycle.
// Backpressure: stall freezes the core during RUN and holds result/tag in HOLD; a new op is accepted only in IDLE or on grant.
module fu_wb_requester #(
    parameter int DATA_W  = 32,
    parameter int TAG_W   = 5,
    parameter int LATENCY = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [TAG_W-1:0]  start_rd,
    input  logic              start_fp,
    output logic              ready,
    output logic              core_start,
    output logic              core_hold,
    input  logic [DATA_W-1:0] core_result,
    input  logic              stall,
    output logic              p_signal,
    output logic              p_signal_start,
    output logic [DATA_W-1:0] result,
    output logic [TAG_W-1:0]  result_rd,
    output logic              result_fp,
    output logic [TAG_W-1:0]  busy_rd,
    output logic              busy_valid
);
    localparam int CNT_W = $clog2(LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [TAG_W-1:0]  tag_rd;
    logic              tag_fp;
    logic              grant;
    logic              accept;

    // Combinational handshake outputs are forced low while reset is asserted.
    assign grant          = p_signal & ~stall;
    assign ready          = ~reset & ((state == IDLE) | ((state == HOLD) & grant));
    assign accept         = start & ready;
    assign p_signal_start = accept;
    assign core_start     = accept;
    assign core_hold      = ~reset & (state == RUN) & stall;
    assign busy_rd        = tag_rd;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            p_signal   <= 1'b0;
            busy_valid <= 1'b0;
            result     <= '0;
            result_rd  <= '0;
            result_fp  <= 1'b0;
            tag_rd     <= '0;
            tag_fp     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state      <= RUN;
                        cnt        <= CNT_INIT;
                        tag_rd     <= start_rd;
                        tag_fp     <= start_fp;
                        busy_valid <= 1'b1;
                    end
                end
                RUN: begin
                    if (!stall) begin
                        if (cnt != '0) begin
                            cnt <= cnt - 1'b1;
                        end else begin
                            result    <= core_result;
                            result_rd <= tag_rd;
                            result_fp <= tag_fp;
                            p_signal  <= 1'b1;
                            state     <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    // Grant with a new start relaunches in the same edge; result regs stay untouched until the next capture.
                    if (grant) begin
                        p_signal <= 1'b0;
                        if (accept) begin
                            state  <= RUN;
                            cnt    <= CNT_INIT;
                            tag_rd <= start_rd;
                            tag_fp <= start_fp;
                        end else begin
                            state      <= IDLE;
                            busy_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    state      <= IDLE;
                    p_signal   <= 1'b0;
                    busy_valid <= 1'b0;
                end
            endcase
        end
    end

    // Issuing while not ready is an upstream protocol error; the request is dropped.
    always_ff @(posedge clk) begin
        assert (reset || !start || ready)
            else $warning("fu_wb_requester: start ignored while not ready");
    end
endmodule

// File: tb/tb_fu_wb_requester.sv
// Randomized and directed bench for fu_wb_requester, checked every cycle against a transaction-level model.
module tb_fu_wb_requester;
    localparam int DATA_W  = 32;
    localparam int TAG_W   = 5;
    localparam int LATENCY = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [TAG_W-1:0]  start_rd = '0;
    logic              start_fp = 1'b0;
    logic              ready;
    logic              core_start;
    logic              core_hold;
    logic [DATA_W-1:0] core_result = '0;
    logic              stall = 1'b0;
    logic              p_signal;
    logic              p_signal_start;
    logic [DATA_W-1:0] result;
    logic [TAG_W-1:0]  result_rd;
    logic              result_fp;
    logic [TAG_W-1:0]  busy_rd;
    logic              busy_valid;

    fu_wb_requester #(
        .DATA_W (DATA_W),
        .TAG_W  (TAG_W),
        .LATENCY(LATENCY)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .start_rd      (start_rd),
        .start_fp      (start_fp),
        .ready         (ready),
        .core_start    (core_start),
        .core_hold     (core_hold),
        .core_result   (core_result),
        .stall         (stall),
        .p_signal      (p_signal),
        .p_signal_start(p_signal_start),
        .result        (result),
        .result_rd     (result_rd),
        .result_fp     (result_fp),
        .busy_rd       (busy_rd),
        .busy_valid    (busy_valid)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Transaction-level model: one op either computing (m_left unstalled cycles to go) or waiting for grant.
    logic              m_run    = 1'b0;
    logic              m_hold   = 1'b0;
    int                m_left   = 0;
    logic [TAG_W-1:0]  m_tag    = '0;
    logic              m_fp     = 1'b0;
    logic [DATA_W-1:0] m_res    = '0;
    logic [TAG_W-1:0]  m_res_rd = '0;
    logic              m_res_fp = 1'b0;

    int   cyc     = 0;
    int   acc_cyc = 0;
    int   stalls  = 0;
    logic prev_p  = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %0h, expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic cycle(input logic st, input logic [TAG_W-1:0] rd, input logic fp,
                         input logic sl, input logic rs, input logic [DATA_W-1:0] cr);
        logic e_ready;
        logic acc;
        @(posedge clk);
        #1;
        start       = st;
        start_rd    = rd;
        start_fp    = fp;
        stall       = sl;
        reset       = rs;
        core_result = cr;
        cyc++;
        @(negedge clk);
        e_ready = !rs && ((!m_run && !m_hold) || (m_hold && !sl));
        acc     = st && e_ready;
        chk("ready",          64'(ready),          64'(e_ready));
        chk("p_signal_start", 64'(p_signal_start), 64'(acc));
        chk("core_start",     64'(core_start),     64'(acc));
        chk("core_hold",      64'(core_hold),      64'(!rs && m_run && sl));
        chk("p_signal",       64'(p_signal),       64'(m_hold));
        chk("busy_valid",     64'(busy_valid),     64'(m_run || m_hold));
        chk("busy_rd",        64'(busy_rd),        64'(m_tag));
        chk("result",         64'(result),         64'(m_res));
        chk("result_rd",      64'(result_rd),      64'(m_res_rd));
        chk("result_fp",      64'(result_fp),      64'(m_res_fp));
        // First p_signal cycle follows the LATENCY-th edge after the accepting one, pushed out by stalls.
        if (p_signal === 1'b1 && prev_p !== 1'b1)
            chk("latency", 64'(cyc - acc_cyc), 64'(LATENCY + 1 + stalls));
        prev_p = p_signal;

        if (rs) begin
            m_run    = 1'b0;
            m_hold   = 1'b0;
            m_tag    = '0;
            m_fp     = 1'b0;
            m_res    = '0;
            m_res_rd = '0;
            m_res_fp = 1'b0;
        end else begin
            if (m_run && sl) begin
                stalls++;
            end else if (m_run) begin
                m_left--;
                if (m_left == 0) begin
                    m_res    = cr;
                    m_res_rd = m_tag;
                    m_res_fp = m_fp;
                    m_run    = 1'b0;
                    m_hold   = 1'b1;
                end
            end else if (m_hold && !sl) begin
                m_hold = 1'b0;
            end
            if (acc) begin
                m_run   = 1'b1;
                m_hold  = 1'b0;
                m_left  = LATENCY;
                m_tag   = rd;
                m_fp    = fp;
                acc_cyc = cyc;
                stalls  = 0;
            end
        end
    endtask

    task automatic idle(input int n, input logic sl);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, sl, 1'b0, 32'hDEADBEEF);
    endtask

    initial begin
        logic             st;
        logic [TAG_W-1:0] rd;
        repeat (2) @(posedge clk);

        // Reset state
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF);
        idle(2, 1'b0);

        // Basic latency, tag 7
        cycle(1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF);
        idle(20, 1'b0);

        // Result held through 5 stalled HOLD cycles
        cycle(1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF);
        idle(LATENCY, 1'b0);
        idle(5, 1'b1);
        idle(4, 1'b0);

        // Stall during RUN, 3 cycles starting 4 cycles in
        cycle(1'b1, 5'd21, 1'b0, 1'b0, 1'b0, 32'h12345678);
        idle(3, 1'b0);
        idle(3, 1'b1);
        for (int i = 0; i < 20; i++) cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 32'h12345678);

        // Back-to-back: relaunch with tag 12 on the granting edge
        cycle(1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 32'hCAFEF00D);
        idle(LATENCY, 1'b0);
        cycle(1'b1, 5'd12, 1'b1, 1'b0, 1'b0, 32'hCAFEF00D);
        for (int i = 0; i < 20; i++) cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 32'h0BADC0DE);

        // Illegal start during RUN is dropped
        cycle(1'b1, 5'd4, 1'b0, 1'b0, 1'b0, 32'h55AA55AA);
        idle(5, 1'b0);
        cycle(1'b1, 5'd20, 1'b1, 1'b0, 1'b0, 32'h55AA55AA);
        idle(14, 1'b0);

        // Reset mid-RUN, then reset while in HOLD
        cycle(1'b1, 5'd30, 1'b1, 1'b0, 1'b0, 32'h11111111);
        idle(7, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, 32'h11111111);
        idle(20, 1'b0);
        cycle(1'b1, 5'd17, 1'b0, 1'b0, 1'b0, 32'h22222222);
        idle(LATENCY, 1'b0);
        idle(2, 1'b1);
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b1, 32'h22222222);
        idle(20, 1'b0);

        // Randomized traffic; starts mostly legal, occasional violation and reset
        for (int i = 0; i < 3000; i++) begin
            if ((!m_run && !m_hold) || m_hold)
                st = ($urandom_range(0, 2) == 0);
            else
                st = ($urandom_range(0, 199) == 0);
            rd = TAG_W'($urandom);
            cycle(st, rd, 1'($urandom), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 299) == 0), $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
